// File: rtl/mux_scan_sequencer_if.sv
// Purpose : bundles the start/data request, the mux-facing D/S/out lines and the scan results.
// Latency : none, wiring only.
// Backpres: none; start is a level request that the sequencer samples only while idle.
//
// Ports (master = sequencer side, slave = requester plus the mux under test):
//   start, data_in          request and word to scan
//   D0..D7, S0..S2          data and select lines towards the 8:1 mux
//   mux_out                 combinational return from the mux
//   ser_out, ser_valid      serial sample stream, one pulse per select value
//   captured, busy, done    reassembled word and scan status
//   err                     compare result, held until the next accepted start
interface mux_scan_if;
    logic       start;
    logic [7:0] data_in;
    logic       D0, D1, D2, D3, D4, D5, D6, D7;
    logic       S0, S1, S2;
    logic       mux_out;
    logic       ser_out;
    logic       ser_valid;
    logic [7:0] captured;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        input  start, data_in, mux_out,
        output D0, D1, D2, D3, D4, D5, D6, D7,
        output S0, S1, S2,
        output ser_out, ser_valid, captured, busy, done, err
    );

    modport slave (
        output start, data_in, mux_out,
        input  D0, D1, D2, D3, D4, D5, D6, D7,
        input  S0, S1, S2,
        input  ser_out, ser_valid, captured, busy, done, err
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Purpose : drives a latched word into an 8:1 mux, walks the selects 0..7, captures and compares the output.
// Latency : start accepted at edge 0, samples at edges DIV..8*DIV, done high the cycle after edge 8*DIV.
// Backpres: start is ignored while busy (STEP/DONE) and on the first edge after reset release.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   bus      mux_scan_if.master: start/data_in in, D0..D7/S0..S2 out, mux_out in,
//            ser_out/ser_valid/captured/busy/done/err out
module mux_scan_sequencer #(
    parameter int unsigned DIV   = 1,   // cycles per select step, 0 behaves as 1
    parameter int unsigned DIV_W = 4    // width of the step divider
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_scan_if.master     bus
);

    localparam int unsigned      DIV_EFF  = (DIV == 0) ? 1 : DIV;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_EFF - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    // Stays low for the first edge after reset release so a start that is
    // already high when reset lifts is not taken on that same edge.
    logic             armed_q;

    logic [7:0]       d_reg;
    logic [2:0]       sel_q;
    logic [DIV_W-1:0] div_q;
    logic [7:0]       captured_q;
    logic             ser_out_q;
    logic             ser_valid_q;
    logic             err_q;

    logic             accept;
    logic             sample;
    logic             last_sample;
    logic             busy;
    logic             done;
    logic [7:0]       cap_next;

    //------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    //------------------------------------------------------------------
    // Next state and control strobes
    //------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        sample      = 1'b0;
        last_sample = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        // Captured word including the bit being sampled this cycle, so the
        // final compare sees the sel=7 sample taken on the DONE entry edge.
        cap_next        = captured_q;
        cap_next[sel_q] = bus.mux_out;

        case (state_q)
            IDLE: begin
                if (bus.start && armed_q) begin
                    accept  = 1'b1;
                    state_d = STEP;
                end
            end
            STEP: begin
                busy = 1'b1;
                if (div_q == DIV_LAST) begin
                    sample = 1'b1;
                    if (sel_q == 3'd7) begin
                        last_sample = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------
    // Datapath: latched word, select walk, divider, capture and compare
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q     <= 1'b0;
            d_reg       <= 8'h00;
            sel_q       <= 3'd0;
            div_q       <= '0;
            captured_q  <= 8'h00;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            armed_q     <= 1'b1;
            ser_valid_q <= 1'b0;

            if (accept) begin
                d_reg      <= bus.data_in;
                sel_q      <= 3'd0;
                div_q      <= '0;
                captured_q <= 8'h00;
                err_q      <= 1'b0;
            end else if (state_q == STEP) begin
                if (sample) begin
                    captured_q  <= cap_next;
                    ser_out_q   <= bus.mux_out;
                    ser_valid_q <= 1'b1;
                    div_q       <= '0;
                    if (last_sample) begin
                        // sel stays at 7 until the next accepted start
                        err_q <= (cap_next != d_reg);
                    end else begin
                        sel_q <= sel_q + 3'd1;
                    end
                end else begin
                    div_q <= div_q + 1'b1;
                end
            end
        end
    end

    //------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------
    assign bus.D0 = d_reg[0];
    assign bus.D1 = d_reg[1];
    assign bus.D2 = d_reg[2];
    assign bus.D3 = d_reg[3];
    assign bus.D4 = d_reg[4];
    assign bus.D5 = d_reg[5];
    assign bus.D6 = d_reg[6];
    assign bus.D7 = d_reg[7];

    assign bus.S0 = sel_q[0];
    assign bus.S1 = sel_q[1];
    assign bus.S2 = sel_q[2];

    assign bus.ser_out   = ser_out_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.captured  = captured_q;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Purpose : directed bench for mux_scan_sequencer with DIV=1 and DIV=3 instances and an ideal/stuck mux model.
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpres: none; start is driven directly by the bench.
module tb_mux_scan_sequencer;

    logic clk;
    logic rst_n;
    logic stuck1;

    int total;
    int passed;
    int failed;

    mux_scan_if if1 ();
    mux_scan_if if3 ();

    mux_scan_sequencer #(.DIV(1), .DIV_W(4)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    mux_scan_sequencer #(.DIV(3), .DIV_W(4)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if3)
    );

    logic [7:0] d1;
    logic [2:0] s1;
    logic [7:0] d3;
    logic [2:0] s3;

    assign d1 = {if1.D7, if1.D6, if1.D5, if1.D4, if1.D3, if1.D2, if1.D1, if1.D0};
    assign s1 = {if1.S2, if1.S1, if1.S0};
    assign d3 = {if3.D7, if3.D6, if3.D5, if3.D4, if3.D3, if3.D2, if3.D1, if3.D0};
    assign s3 = {if3.S2, if3.S1, if3.S0};

    // Ideal zero-latency 8:1 mux, optionally stuck at 0 on the DIV=1 side
    assign if1.mux_out = stuck1 ? 1'b0 : d1[s1];
    assign if3.mux_out = d3[s3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] pat;
    int         nvalid;

    initial begin
        total  = 0;
        passed = 0;
        failed = 0;
        rst_n  = 1'b0;
        stuck1 = 1'b0;
        if1.start   = 1'b0;
        if1.data_in = 8'h00;
        if3.start   = 1'b0;
        if3.data_in = 8'h00;

        // ---------------- reset state ----------------
        repeat (3) tick();
        chk("rst_d1", d1, 8'h00);
        chk("rst_s1", s1, 3'd0);
        chk("rst_flags1", {if1.ser_out, if1.ser_valid, if1.busy, if1.done, if1.err}, 5'b0);
        chk("rst_cap1", if1.captured, 8'h00);
        chk("rst_flags3", {if3.ser_out, if3.ser_valid, if3.busy, if3.done, if3.err}, 5'b0);

        // ------- release with start already high: first edge ignored -------
        rst_n       = 1'b1;
        if1.start   = 1'b1;
        if1.data_in = 8'hA5;
        tick();
        chk("rel_start_ignored", if1.busy, 1'b0);

        // ---------------- DIV=1, A5 ----------------
        tick();                               // edge 0
        if1.start = 1'b0;
        chk("a5_busy0", if1.busy, 1'b1);
        chk("a5_s0", s1, 3'd0);
        chk("a5_d", d1, 8'hA5);
        pat = 8'hA5;
        for (int k = 1; k <= 8; k++) begin
            if (k == 4) begin
                // start pulse and data change while busy must be ignored
                if1.start   = 1'b1;
                if1.data_in = 8'h00;
            end
            tick();
            if1.start = 1'b0;
            chk($sformatf("a5_valid_%0d", k), if1.ser_valid, 1'b1);
            chk($sformatf("a5_ser_%0d", k), if1.ser_out, pat[k-1]);
            chk($sformatf("a5_sel_%0d", k), s1, (k < 8) ? k : 7);
            chk($sformatf("a5_done_%0d", k), if1.done, (k == 8));
        end
        chk("a5_cap", if1.captured, 8'hA5);
        chk("a5_err", if1.err, 1'b0);
        chk("a5_d_hold", d1, 8'hA5);
        tick();                               // edge 9
        chk("a5_busy9", if1.busy, 1'b0);
        chk("a5_done9", if1.done, 1'b0);
        chk("a5_s_hold", s1, 3'd7);
        chk("a5_valid9", if1.ser_valid, 1'b0);
        tick();
        chk("a5_no_retrigger", if1.busy, 1'b0);

        // ---------------- stuck-at-0, FF ----------------
        stuck1      = 1'b1;
        if1.data_in = 8'hFF;
        if1.start   = 1'b1;
        tick();
        if1.start = 1'b0;
        repeat (8) tick();
        chk("stk_done", if1.done, 1'b1);
        chk("stk_cap", if1.captured, 8'h00);
        chk("stk_err", if1.err, 1'b1);
        repeat (4) tick();
        chk("stk_err_held", if1.err, 1'b1);
        chk("stk_idle", if1.busy, 1'b0);

        // ---------------- data_in changes mid-scan ----------------
        stuck1      = 1'b0;
        if1.data_in = 8'h00;
        if1.start   = 1'b1;
        tick();                               // edge 0
        if1.start = 1'b0;
        chk("chg_err_cleared", if1.err, 1'b0);
        repeat (2) tick();
        if1.data_in = 8'hFF;
        repeat (6) tick();                    // edge 8
        chk("chg_done", if1.done, 1'b1);
        chk("chg_cap", if1.captured, 8'h00);
        chk("chg_err", if1.err, 1'b0);
        chk("chg_d", d1, 8'h00);
        tick();

        // ---------------- reset mid-scan ----------------
        if1.data_in = 8'h5A;
        if1.start   = 1'b1;
        tick();                               // edge 0
        if1.start = 1'b0;
        repeat (3) tick();                    // three samples taken
        chk("abort_partial_cap", if1.captured, 8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_d", d1, 8'h00);
        chk("abort_s", s1, 3'd0);
        chk("abort_flags", {if1.ser_out, if1.ser_valid, if1.busy, if1.done, if1.err}, 5'b0);
        chk("abort_cap", if1.captured, 8'h00);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("abort_nodone_%0d", k), if1.done, 1'b0);
        end
        rst_n       = 1'b1;
        if1.data_in = 8'h96;
        if1.start   = 1'b1;
        tick();
        chk("abort_rel_ignored", if1.busy, 1'b0);
        tick();                               // edge 0
        if1.start = 1'b0;
        repeat (8) tick();
        chk("abort_rescan_done", if1.done, 1'b1);
        chk("abort_rescan_cap", if1.captured, 8'h96);
        chk("abort_rescan_err", if1.err, 1'b0);
        tick();

        // ---------------- start held high for 20 edges ----------------
        if1.data_in = 8'hC3;
        if1.start   = 1'b1;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (e == 8)  chk("hold_done8", if1.done, 1'b1);
            if (e == 9)  chk("hold_idle9", if1.busy, 1'b0);
            if (e == 10) chk("hold_busy10", {if1.busy, s1}, {1'b1, 3'd0});
            if (e == 18) chk("hold_done18", if1.done, 1'b1);
            if (e == 18) chk("hold_cap18", if1.captured, 8'hC3);
            if (e == 19) chk("hold_idle19", if1.busy, 1'b0);
        end
        if1.start = 1'b0;
        tick();
        chk("hold_stop", if1.busy, 1'b0);

        // ---------------- DIV=3, 3C ----------------
        if3.data_in = 8'h3C;
        if3.start   = 1'b1;
        tick();                               // edge 0
        if3.start = 1'b0;
        chk("d3_busy0", if3.busy, 1'b1);
        chk("d3_s0", s3, 3'd0);
        pat    = 8'h3C;
        nvalid = 0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (if3.ser_valid) nvalid++;
            chk($sformatf("d3_valid_%0d", k), if3.ser_valid, (k % 3 == 0));
            if (k % 3 == 0) chk($sformatf("d3_ser_%0d", k), if3.ser_out, pat[k/3-1]);
            chk($sformatf("d3_sel_%0d", k), s3, (k / 3 > 7) ? 7 : k / 3);
            chk($sformatf("d3_done_%0d", k), if3.done, (k == 24));
        end
        chk("d3_nvalid", nvalid, 8);
        chk("d3_cap", if3.captured, 8'h3C);
        chk("d3_err", if3.err, 1'b0);
        tick();
        chk("d3_idle", if3.busy, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
